// File: rtl/beta_prefetch_buffer_if.sv
// Instruction memory bus between the prefetch buffer and the fetch port.
// Master issues single requests; slave accepts and returns one response each.
interface beta_prefetch_buffer_if #(
  parameter int DataWidth = 32
);
  logic                 instr_req;
  logic [DataWidth-1:0] instr_addr;
  logic                 instr_ready;
  logic                 instr_valid;
  logic [DataWidth-1:0] instr_rdata;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_ready,
    input  instr_valid,
    input  instr_rdata
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_ready,
    output instr_valid,
    output instr_rdata
  );
endinterface

// File: rtl/beta_prefetch_buffer.sv
// Sequential instruction prefetcher: one outstanding fetch, {addr,instr} FIFO.
// Optional same-cycle bypass of an empty FIFO under `BETA_PFB_BYPASS_EN.
module beta_prefetch_buffer #(
  parameter int                   DataWidth = 32,
  parameter int                   Depth     = 4,
  parameter logic [DataWidth-1:0] BootAddr  = '0
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   pfb_fetch_en_i,
  input  logic                   pfb_flush_i,
  input  logic [DataWidth-1:0]   pfb_flush_addr_i,
  beta_prefetch_buffer_if.master mem,
  output logic                   pfb_valid_o,
  input  logic                   pfb_ready_i,
  output logic [DataWidth-1:0]   pfb_instr_o,
  output logic [DataWidth-1:0]   pfb_addr_o,
  output logic [$clog2(Depth):0] pfb_count_o,
  output logic                   pfb_busy_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(Depth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  typedef struct packed {
    logic [DataWidth-1:0] addr;
    logic [DataWidth-1:0] instr;
  } entry_t;

  state_e state_q;
  state_e state_d;

  logic [DataWidth-1:0] fetch_addr_q;
  logic [DataWidth-1:0] req_addr_q;
  logic [DataWidth-1:0] flush_target;

  entry_t          fifo_q [Depth];
  entry_t          head;
  entry_t          resp_entry;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW:0]   count_q;

  logic space;
  logic req;
  logic accept;
  logic resp;
  logic bypass;
  logic pop_fifo;
  logic wr_en;

  assign space        = count_q < DepthC;
  assign accept       = req & mem.instr_ready;
  assign flush_target = pfb_flush_addr_i & ~DataWidth'(3);
  assign head         = fifo_q[rd_ptr_q];
  assign resp_entry   = '{addr: req_addr_q,
                          instr: mem.instr_rdata};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A flush with an accepted request or a live response makes it stale.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = pfb_flush_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.instr_valid) begin
          state_d = S_IDLE;
        end else if (pfb_flush_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem.instr_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req  = 1'b0;
    resp = 1'b0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        req = rstn_i & pfb_fetch_en_i & space;
      end
      state_q == S_WAIT: begin
        resp = mem.instr_valid & ~pfb_flush_i;
      end
      default: ;
    endcase
  end

  assign mem.instr_req  = req;
  assign mem.instr_addr = fetch_addr_q;
  assign pfb_busy_o     = state_q != S_IDLE;
  assign pfb_count_o    = count_q;

`ifdef BETA_PFB_BYPASS_EN
  assign bypass      = resp & (count_q == '0);
  assign pfb_valid_o = (count_q != '0) | bypass;
  assign pfb_instr_o = bypass ? resp_entry.instr
                              : head.instr;
  assign pfb_addr_o  = bypass ? resp_entry.addr
                              : head.addr;
`else
  assign bypass      = 1'b0;
  assign pfb_valid_o = count_q != '0;
  assign pfb_instr_o = head.instr;
  assign pfb_addr_o  = head.addr;
`endif

  assign pop_fifo = (count_q != '0) & pfb_ready_i
                  & ~pfb_flush_i;
  assign wr_en    = resp & ~(bypass & pfb_ready_i);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_addr_q <= BootAddr;
      req_addr_q   <= '0;
    end else begin
      if (pfb_flush_i) begin
        fetch_addr_q <= flush_target;
      end else if (accept) begin
        fetch_addr_q <= fetch_addr_q + DataWidth'(4);
      end
      if (accept) begin
        req_addr_q <= fetch_addr_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < Depth; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (pfb_flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        fifo_q[wr_ptr_q] <= resp_entry;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop_fifo) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({wr_en, pop_fifo})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// Directed bench for beta_prefetch_buffer with a latency-programmable
// memory model and an {addr,instr} scoreboard of expected FIFO output.
module tb_beta_prefetch_buffer;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn_i;
  logic          pfb_fetch_en_i;
  logic          pfb_flush_i;
  logic [DW-1:0] pfb_flush_addr_i;
  logic          pfb_valid_o;
  logic          pfb_ready_i;
  logic [DW-1:0] pfb_instr_o;
  logic [DW-1:0] pfb_addr_o;
  logic [2:0]    pfb_count_o;
  logic          pfb_busy_o;

  beta_prefetch_buffer_if #(.DataWidth(DW)) mem_if ();

  beta_prefetch_buffer dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .pfb_fetch_en_i   (pfb_fetch_en_i),
    .pfb_flush_i      (pfb_flush_i),
    .pfb_flush_addr_i (pfb_flush_addr_i),
    .mem              (mem_if),
    .pfb_valid_o      (pfb_valid_o),
    .pfb_ready_i      (pfb_ready_i),
    .pfb_instr_o      (pfb_instr_o),
    .pfb_addr_o       (pfb_addr_o),
    .pfb_count_o      (pfb_count_o),
    .pfb_busy_o       (pfb_busy_o)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] sbq [$];
  logic [31:0] popq [$];
  logic [31:0] exp_fetch;
  int          lat;
  bit          pend, pstale, rlive, rstale, saw_zero;
  int          pcnt, n_acc, n_pop;
  logic [31:0] paddr, raddr, last_acc;
  bit          found;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    int n0;
    bit pushed;
    logic [63:0] e;
    @(negedge clk);
    n0 = sbq.size();
    pushed = rstn_i && rlive && !rstale
          && !pfb_flush_i && mem_if.instr_valid;
    chk("count", 32'(pfb_count_o), 32'(n0));
`ifdef BETA_PFB_BYPASS_EN
    chk("valid", 32'(pfb_valid_o),
        32'((n0 != 0) || pushed));
`else
    chk("valid", 32'(pfb_valid_o), 32'(n0 != 0));
`endif
    if (pushed) sbq.push_back({raddr, rd(raddr)});
    if (!rstn_i || pfb_flush_i) begin
      sbq.delete();
    end else if (pfb_valid_o && pfb_ready_i) begin
      if (sbq.size() == 0) begin
        chk("pop_empty", 32'(sbq.size()), 1);
      end else begin
        e = sbq.pop_front();
        chk("pop_addr", pfb_addr_o, e[63:32]);
        chk("pop_instr", pfb_instr_o, e[31:0]);
        popq.push_back(pfb_addr_o);
        n_pop++;
      end
    end
    if (rstn_i && mem_if.instr_req
        && mem_if.instr_ready) begin
      chk("req_addr", mem_if.instr_addr, exp_fetch);
      n_acc++;
      last_acc = mem_if.instr_addr;
      if (mem_if.instr_addr == 0) saw_zero = 1;
      exp_fetch = exp_fetch + 4;
      pend   = 1;
      pcnt   = lat;
      paddr  = mem_if.instr_addr;
      pstale = pfb_flush_i;
    end
    if (pfb_flush_i) begin
      exp_fetch = pfb_flush_addr_i & ~32'd3;
      pstale = 1;
    end
    if (!rstn_i) begin
      exp_fetch = 0;
      pstale = 1;
      rstale = 1;
    end
    @(posedge clk);
    #1;
    rlive = 0;
    mem_if.instr_valid = 1'b0;
    mem_if.instr_rdata = '0;
    if (pend) begin
      pcnt--;
      if (pcnt <= 0) begin
        pend   = 0;
        rlive  = 1;
        raddr  = paddr;
        rstale = pstale;
        mem_if.instr_valid = 1'b1;
        mem_if.instr_rdata = rd(paddr);
      end
    end
  endtask

  initial begin
    rstn_i = 0; pfb_fetch_en_i = 0; pfb_flush_i = 0;
    pfb_flush_addr_i = '0; pfb_ready_i = 1;
    mem_if.instr_ready = 1'b1;
    mem_if.instr_valid = 1'b0;
    mem_if.instr_rdata = '0;
    lat = 1; exp_fetch = 0; pend = 0; pstale = 0;
    rlive = 0; rstale = 0; pcnt = 0; n_acc = 0;
    n_pop = 0; saw_zero = 0; paddr = 0; raddr = 0;
    last_acc = 0;
    @(posedge clk); #1;
    tick();
    rstn_i = 1;
    chk("rst_req", 32'(mem_if.instr_req), 0);
    chk("rst_addr", mem_if.instr_addr, 0);
    chk("rst_valid", 32'(pfb_valid_o), 0);
    chk("rst_count", 32'(pfb_count_o), 0);
    chk("rst_busy", 32'(pfb_busy_o), 0);
    chk("rst_instr", pfb_instr_o, 0);
    chk("rst_paddr", pfb_addr_o, 0);

    // 1: streaming fetch, consumer always ready
    pfb_fetch_en_i = 1;
    repeat (10) tick();
`ifdef BETA_PFB_BYPASS_EN
    chk("t1_npop", 32'(n_pop), 5);
`else
    chk("t1_npop", 32'(n_pop), 4);
`endif
    chk("t1_pop0", popq[0], 32'h0);
    chk("t1_pop1", popq[1], 32'h4);
    chk("t1_pop2", popq[2], 32'h8);

    // 2: stalled consumer fills FIFO, one pop frees one slot
    pfb_fetch_en_i = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (!pfb_busy_o && sbq.size() == 0) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t2_drain", 32'(found), 1);
    rstn_i = 0;
    tick();
    rstn_i = 1; pfb_ready_i = 0; pfb_fetch_en_i = 1;
    n_acc = 0;
    repeat (14) tick();
    chk("t2_nacc", 32'(n_acc), 4);
    chk("t2_full", 32'(pfb_count_o), 4);
    chk("t2_noreq", 32'(mem_if.instr_req), 0);
    pfb_ready_i = 1;
    tick();
    pfb_ready_i = 0;
    repeat (4) tick();
    chk("t2_nacc5", 32'(n_acc), 5);
    chk("t2_addr10", last_acc, 32'h10);
    chk("t2_refull", 32'(pfb_count_o), 4);

    // 3: flush during WAIT, old response arrives later
    pfb_ready_i = 1; lat = 3;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (pfb_busy_o && !mem_if.instr_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t3_found", 32'(found), 1);
    pfb_flush_i = 1; pfb_flush_addr_i = 32'h203;
    tick();
    pfb_flush_i = 0;
    popq.delete();
    repeat (12) tick();
    chk("t3_first", popq[0], 32'h200);

    // 4: flush coincident with an accepted request
    lat = 1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_if.instr_req) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t4_found", 32'(found), 1);
    pfb_flush_i = 1; pfb_flush_addr_i = 32'h300;
    tick();
    pfb_flush_i = 0;
    chk("t4_drop", 32'(pfb_busy_o), 1);
    popq.delete();
    repeat (10) tick();
    chk("t4_first", popq[0], 32'h300);

    // 5: address wrap
    pfb_flush_i = 1; pfb_flush_addr_i = 32'hFFFF_FFFE;
    tick();
    pfb_flush_i = 0;
    saw_zero = 0;
    popq.delete();
    repeat (12) tick();
    chk("t5_wrap", 32'(saw_zero), 1);
    chk("t5_pop0", popq[0], 32'hFFFF_FFFC);
    chk("t5_pop1", popq[1], 32'h0);

    // 6: reset in WAIT with three entries queued
    lat = 3; pfb_ready_i = 0;
    pfb_flush_i = 1; pfb_flush_addr_i = 32'h400;
    tick();
    pfb_flush_i = 0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() == 3 && pfb_busy_o
          && !mem_if.instr_valid) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t6_found", 32'(found), 1);
    chk("t6_cnt3", 32'(pfb_count_o), 3);
    rstn_i = 0; pfb_fetch_en_i = 0;
    tick();
    rstn_i = 1;
    chk("t6_cnt0", 32'(pfb_count_o), 0);
    chk("t6_addr", mem_if.instr_addr, 0);
    chk("t6_busy", 32'(pfb_busy_o), 0);
    repeat (5) tick();
    pfb_fetch_en_i = 1; pfb_ready_i = 1;
    popq.delete();
    repeat (12) tick();
    chk("t6_first", popq[0], 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
